// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: feeds an 8x8 output-stationary PE cluster.
// Beats are accepted one per handshake and then diagonally skewed, so lane i
// is presented i cycles after lane 0. A last flag travels with each beat.
// After the final beat the skew is flushed, en is held while partial sums
// settle, and a one-cycle tile_done marks the cycle where results are valid.
// DRAIN_CYCLES is assumed to be at least 1.
module systolic_skew_feeder #(
  parameter int LANES        = 8,
  parameter int DW           = 16,
  parameter int MAX_K        = 256,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_act,
  input  logic [LANES*DW-1:0]   in_wgt,
  input  logic                  in_last,
  output logic [LANES*DW-1:0]   activations,
  output logic [LANES*DW-1:0]   weights,
  output logic [LANES-1:0]      done,
  output logic                  en,
  output logic                  busy,
  output logic                  tile_done
);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    DRAIN,
    FINISH
  } state_t;

  localparam int PW = 8;

  state_t          state;
  logic [8:0]      beat_cnt;
  logic [PW-1:0]   phase_cnt;

  logic                 accept;
  logic                 beat_last;
  logic [LANES*DW-1:0]  lane_act_in;
  logic [LANES*DW-1:0]  lane_wgt_in;
  logic                 lane_last_in;

  // Ready only in the accepting states, and never while reset is held.
  assign in_ready = !rst && ((state == IDLE) || (state == STREAM));
  assign accept   = in_valid && in_ready;

  // The beat reaching MAX_K closes the tile even without in_last.
  assign beat_last = in_last || (beat_cnt == 9'(MAX_K - 1));

  // Cycles without an accepted beat inject zeros, which add nothing to a MAC.
  assign lane_act_in  = accept ? in_act : '0;
  assign lane_wgt_in  = accept ? in_wgt : '0;
  assign lane_last_in = accept && beat_last;

  // Tile sequencer with registered en, busy and tile_done.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      phase_cnt <= '0;
      en        <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            beat_cnt <= 9'd1;
            en       <= 1'b1;
            busy     <= 1'b1;
            if (beat_last) begin
              state     <= FLUSH;
              phase_cnt <= PW'(LANES - 1);
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (beat_last) begin
              state     <= FLUSH;
              phase_cnt <= PW'(LANES - 1);
            end
          end
        end
        FLUSH: begin
          // Ends on the cycle the last lane shows its final element.
          if (phase_cnt == '0) begin
            state     <= DRAIN;
            phase_cnt <= PW'(DRAIN_CYCLES - 1);
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        DRAIN: begin
          if (phase_cnt == '0) begin
            state     <= FINISH;
            tile_done <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        FINISH: begin
          // en drops after the results-valid cycle, clearing the array.
          state    <= IDLE;
          en       <= 1'b0;
          busy     <= 1'b0;
          beat_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Lane i gets i+1 register stages, producing the diagonal skew.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] act_sr  [0:i];
    logic [DW-1:0] wgt_sr  [0:i];
    logic          last_sr [0:i];

    // Shift this lane's activation, weight and last flag one stage per cycle.
    // NOTE: the skew registers are reset so an aborted tile leaves no stale
    // elements or last flags in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) begin
          act_sr[s]  <= '0;
          wgt_sr[s]  <= '0;
          last_sr[s] <= 1'b0;
        end
      end else begin
        act_sr[0]  <= lane_act_in[i*DW +: DW];
        wgt_sr[0]  <= lane_wgt_in[i*DW +: DW];
        last_sr[0] <= lane_last_in;
        for (int s = 1; s <= i; s++) begin
          act_sr[s]  <= act_sr[s-1];
          wgt_sr[s]  <= wgt_sr[s-1];
          last_sr[s] <= last_sr[s-1];
        end
      end
    end

    assign activations[i*DW +: DW] = act_sr[i];
    assign weights[i*DW +: DW]     = wgt_sr[i];
    assign done[i]                 = last_sr[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder. A per-lane scoreboard holds the element
// each lane must show at a given cycle; a monitor pops and compares them and
// requires zeros on every lane with nothing due. A behavioural 8x8 cluster
// consumes the skewed streams for the end-to-end matrix product.
module tb_systolic_skew_feeder;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int MAX_K = 256;
  localparam int D     = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] in_act = '0;
  logic [LANES*DW-1:0] in_wgt = '0;
  logic                in_last = 1'b0;
  logic [LANES*DW-1:0] activations;
  logic [LANES*DW-1:0] weights;
  logic [LANES-1:0]    done;
  logic                en;
  logic                busy;
  logic                tile_done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .LANES(LANES), .DW(DW), .MAX_K(MAX_K), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
    .activations(activations), .weights(weights), .done(done),
    .en(en), .busy(busy), .tile_done(tile_done)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] act;
    logic [DW-1:0] wgt;
    logic          last;
  } lane_exp_t;

  lane_exp_t lane_q [LANES][$];
  int        td_q[$];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   last_td_cyc = -1;
  int   last_accept_cyc = -1;
  logic accept_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural output-stationary cluster: a flows right, w flows down.
  logic [DW-1:0] pe_a [LANES][LANES];
  logic [DW-1:0] pe_w [LANES][LANES];
  logic [31:0]   acc  [LANES][LANES];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return activations[i*DW +: DW];
    return pe_a[i][j-1];
  endfunction

  function automatic logic [DW-1:0] w_in(input int i, input int j);
    if (i == 0) return weights[j*DW +: DW];
    return pe_w[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        pe_a[i][j] <= en ? a_in(i, j) : '0;
        pe_w[i][j] <= en ? w_in(i, j) : '0;
        acc[i][j]  <= en ? acc[i][j] + 32'(a_in(i, j)) * 32'(w_in(i, j)) : '0;
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    lane_exp_t e;
    int        exp_td;
    if (mon_en) begin
      for (int i = 0; i < LANES; i++) begin
        checks++;
        if (lane_q[i].size() > 0 && lane_q[i][0].due == cyc) begin
          e = lane_q[i].pop_front();
          if ({activations[i*DW +: DW], weights[i*DW +: DW], done[i]} !==
              {e.act, e.wgt, e.last}) begin
            failures++;
            $display("FAIL lane%0d_elem cyc=%0d got act=%h wgt=%h done=%b expected act=%h wgt=%h done=%b",
                     i, cyc, activations[i*DW +: DW], weights[i*DW +: DW], done[i],
                     e.act, e.wgt, e.last);
          end
        end else if ({activations[i*DW +: DW], weights[i*DW +: DW], done[i]} !== '0) begin
          failures++;
          $display("FAIL lane%0d_idle cyc=%0d got act=%h wgt=%h done=%b expected all zero",
                   i, cyc, activations[i*DW +: DW], weights[i*DW +: DW], done[i]);
        end
      end
      if (tile_done === 1'b1) begin
        last_td_cyc = cyc;
        checks++;
        if (td_q.size() == 0) begin
          failures++;
          $display("FAIL tile_done_unexpected cyc=%0d got 1 expected 0", cyc);
        end else begin
          exp_td = td_q.pop_front();
          if (exp_td != cyc) begin
            failures++;
            $display("FAIL tile_done_cycle got %0d expected %0d", cyc, exp_td);
          end
        end
      end else if (td_q.size() > 0 && td_q[0] < cyc) begin
        exp_td = td_q.pop_front();
        checks++;
        failures++;
        $display("FAIL tile_done_missing got none expected at cycle %0d", exp_td);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish expected finish before time limit");
    $fatal(1);
  end

  function automatic logic [LANES*DW-1:0] fill(input int base, input int step);
    logic [LANES*DW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(base + step * i);
    return v;
  endfunction

  function automatic bit lanes_pending();
    for (int i = 0; i < LANES; i++) if (lane_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Offer a beat (entered at a falling edge), wait for acceptance, and
  // queue the per-lane elements and tile_done it must produce.
  task automatic send(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] w,
                      input logic last, input logic exp_last, output int waited);
    int a_cyc;
    in_act   = a;
    in_wgt   = w;
    in_last  = last;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=%b expected 1 within 400 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    a_cyc           = cyc;
    last_accept_cyc = a_cyc;
    accept_en       = en;
    for (int i = 0; i < LANES; i++)
      lane_q[i].push_back('{a_cyc + 1 + i, a[i*DW +: DW], w[i*DW +: DW], exp_last});
    if (exp_last) td_q.push_back(a_cyc + 9 + D);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_act   = '0;
    in_wgt   = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || td_q.size() != 0 || lanes_pending()) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL idle_timeout got busy=%b pending_td=%0d expected idle", busy, td_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (activations !== '0) begin failures++; $display("FAIL rst_activations got %h expected 0", activations); end
    checks++;
    if (weights !== '0) begin failures++; $display("FAIL rst_weights got %h expected 0", weights); end
    checks++;
    if (done !== '0) begin failures++; $display("FAIL rst_done got %b expected 0", done); end
    checks++;
    if (en !== 1'b0) begin failures++; $display("FAIL rst_en got %b expected 0", en); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++;
    if (tile_done !== 1'b0) begin failures++; $display("FAIL rst_tile_done got %b expected 0", tile_done); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b expected 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got %b expected 1", in_ready); end
    mon_en = 1'b1;
  endtask

  task automatic test_single_beat();
    int w;
    int a;
    send(fill(1, 1), fill(16'h10, 1), 1'b1, 1'b1, w);
    a = last_accept_cyc;
    for (int c = a + 1; c <= a + 9 + D; c++) begin
      checks++;
      if (en !== 1'b1) begin failures++; $display("FAIL single_en cyc=%0d got %b expected 1", cyc, en); end
      @(negedge clk);
    end
    checks++;
    if (en !== 1'b0) begin failures++; $display("FAIL single_en_fall cyc=%0d got %b expected 0", cyc, en); end
    checks++;
    if (last_td_cyc != a + 9 + D) begin
      failures++;
      $display("FAIL single_tile_done got %0d expected %0d", last_td_cyc, a + 9 + D);
    end
    wait_idle();
  endtask

  task automatic test_bubble();
    int w;
    send(fill(1, 0), fill(1, 0), 1'b0, 1'b0, w);
    send(fill(2, 0), fill(2, 0), 1'b0, 1'b0, w);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_ready got %b expected 1", in_ready); end
    @(negedge clk);
    send(fill(3, 0), fill(3, 0), 1'b0, 1'b0, w);
    send(fill(4, 0), fill(4, 0), 1'b1, 1'b1, w);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int w;
    int td;
    send(fill(16'h21, 1), fill(16'h121, 1), 1'b0, 1'b0, w);
    send(fill(16'h31, 1), fill(16'h131, 1), 1'b1, 1'b1, w);
    send(fill(16'h41, 1), fill(16'h141, 1), 1'b0, 1'b0, w);
    td = last_td_cyc;
    checks++;
    if (w != 9 + D) begin failures++; $display("FAIL bp_wait got %0d expected %0d", w, 9 + D); end
    checks++;
    if (last_accept_cyc != td + 1) begin
      failures++;
      $display("FAIL bp_accept_cycle got %0d expected %0d", last_accept_cyc, td + 1);
    end
    checks++;
    if (accept_en !== 1'b0) begin failures++; $display("FAIL bp_gap_en got %b expected 0", accept_en); end
    checks++;
    if (en !== 1'b1) begin failures++; $display("FAIL bp_en_rise got %b expected 1", en); end
    send(fill(16'h51, 1), fill(16'h151, 1), 1'b1, 1'b1, w);
    wait_idle();
  endtask

  task automatic test_max_k();
    int w;
    for (int n = 0; n < MAX_K; n++)
      send(fill(n, 1), fill(n + 1000, 3), 1'b0, (n == MAX_K - 1), w);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL maxk_ready got %b expected 0", in_ready); end
    wait_idle();
  endtask

  task automatic test_reset_mid_tile();
    int w;
    int td_before;
    send(fill(16'h61, 1), fill(16'h161, 1), 1'b0, 1'b0, w);
    send(fill(16'h71, 1), fill(16'h171, 1), 1'b1, 1'b1, w);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < LANES; i++) lane_q[i].delete();
    td_q.delete();
    td_before = last_td_cyc;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got %b expected 0", in_ready); end
    @(negedge clk);
    checks++;
    if ({activations, weights, done, en, busy, tile_done} !== '0) begin
      failures++;
      $display("FAIL mid_rst_outputs got en=%b busy=%b td=%b done=%b expected all zero",
               en, busy, tile_done, done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_release got %b expected 1", in_ready); end
    repeat (25) @(negedge clk);
    checks++;
    if (last_td_cyc != td_before) begin
      failures++;
      $display("FAIL mid_rst_no_tile_done got %0d expected %0d", last_td_cyc, td_before);
    end
    send(fill(16'h61, 1), fill(16'h161, 1), 1'b0, 1'b0, w);
    send(fill(16'h71, 1), fill(16'h171, 1), 1'b1, 1'b1, w);
    wait_idle();
  endtask

  task automatic test_end_to_end();
    int w;
    int n;
    int ref_v;
    logic [LANES*DW-1:0] a;
    logic [LANES*DW-1:0] b;
    for (int k = 0; k < LANES; k++) begin
      a = '0;
      b = '0;
      for (int i = 0; i < LANES; i++) a[i*DW +: DW] = DW'(i * LANES + k + 1);
      b[k*DW +: DW] = DW'(1);
      send(a, b, (k == LANES - 1), (k == LANES - 1), w);
    end
    n = 0;
    while (tile_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL e2e_tile_done_timeout got none expected pulse within 100 cycles");
    end else begin
      for (int i = 0; i < LANES; i++) begin
        for (int j = 0; j < LANES; j++) begin
          ref_v = 0;
          for (int k = 0; k < LANES; k++)
            ref_v += (i * LANES + k + 1) * ((k == j) ? 1 : 0);
          checks++;
          if (acc[i][j] !== 32'(ref_v)) begin
            failures++;
            $display("FAIL e2e_result[%0d][%0d] got %0d expected %0d", i, j, acc[i][j], ref_v);
          end
        end
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_bubble();
    test_back_to_back();
    test_max_k();
    test_reset_mid_tile();
    test_end_to_end();
    checks++;
    if (lanes_pending() || td_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d expected 0", td_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
